pgm_video_timing: RTL and testbench
===================================

PGM_VIDEO_TIMING -- requirements
Module: pgm_video_timing

Interface
REQ-001 H_ACTIVE, 640, visible pixels per line.
REQ-002 H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync width, back porch in pixels; each shall be >=1.
REQ-003 V_ACTIVE, 480, visible lines per frame.
REQ-004 V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync width, back porch in lines; each shall be >=1.
REQ-005 HS_POL / VS_POL, 0 / 0, sync active level: 0 = active-low, 1 = active-high.
REQ-006 CNT_W, 12, counter width; shall hold the horizontal total minus 1 and the vertical total minus 1.
REQ-007 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-008 reset_n  in  1  asynchronous active-low reset.
REQ-009 ce_pix  in  1  pixel clock enable; all state advances only on cycles where ce_pix=1.
REQ-010 pattern_sel  in  2  mode: 0 solid, 1 colour bars, 2 grid, 3 pass-through.
REQ-011 solid_rgb  in  24  {R,G,B} for mode 0.
REQ-012 rgb_in  in  24  {R,G,B} pixel for mode 3, aligned with hcnt/vcnt.
REQ-013 hcnt, vcnt  out  CNT_W  current pixel and line position.
REQ-014 hs, vs, de, hblank, vblank  out  1 each  syncs, data enable, blanking flags.
REQ-015 r, g, b  out  8 each  pixel colour.
REQ-016 frame_start, line_start  out  1 each  single-clk_sys-cycle pulses.

Function
REQ-017 Define HT = H_ACTIVE+H_FP+H_SYNC+H_BP and VT = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-018 On a ce_pix cycle, hcnt shall increment, or wrap from HT-1 to 0; vcnt shall increment only on that hcnt wrap, and shall wrap from VT-1 to 0.
REQ-019 On a ce_pix=0 cycle, all registers shall hold their values.
REQ-020 All outputs other than hcnt/vcnt shall be registered on ce_pix cycles from the hcnt/vcnt values present before that edge, giving 1 pixel of latency.
REQ-021 hblank shall be 1 iff hcnt >= H_ACTIVE.
REQ-022 vblank shall be 1 iff vcnt >= V_ACTIVE.
REQ-023 de shall equal ~hblank & ~vblank.
REQ-024 The internal hsync shall be active for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
REQ-025 The internal vsync shall be active for V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC.
REQ-026 Output levels: hs = hsync ? HS_POL : ~HS_POL; vs likewise with VS_POL.
REQ-027 line_start shall be 1 for exactly one clk_sys cycle, the ce_pix edge that registers hcnt=0.
REQ-028 frame_start shall be 1 for exactly one clk_sys cycle, the ce_pix edge that registers hcnt=0 and vcnt=0; at that point line_start shall also be 1.
REQ-029 The active mode shall be latched from pattern_sel only at hcnt=0 and vcnt=0; a pattern_sel change mid-frame shall not affect the current frame.
REQ-030 r/g/b shall be 0 whenever the registered de is 0, in every mode.
REQ-031 Mode 0 shall output solid_rgb, sampled every pixel.
REQ-032 Mode 1 shall output 8 vertical bars, each floor(H_ACTIVE/8) pixels wide, tracked by a bar counter reset at hcnt=0, not by a divider.
REQ-033 Mode 1 bar order is white, yellow, cyan, green, magenta, red, blue, black, with each channel FF or 00; pixels beyond 8 bar widths shall use bar 7.
REQ-034 Mode 2 shall output FFFFFF where hcnt[3:0]=0 or vcnt[3:0]=0, and 000000 elsewhere.
REQ-035 Mode 3 shall register rgb_in with the same 1-pixel latency as de.

Reset
REQ-036 While reset_n=0, hcnt, vcnt, r, g, b, frame_start and line_start shall be 0; de=0; hblank=vblank=0; hs=~HS_POL; vs=~VS_POL; latched mode=0.
REQ-037 A reset_n assertion mid-line shall take effect immediately, asynchronously.
REQ-038 After release, the first ce_pix edge shall produce frame_start=1 and line_start=1.

Verification
REQ-039 Defaults, ce_pix tied to 1 -> hcnt period 800 cycles, frame period 420000 cycles; frame_start once per frame.
REQ-040 Defaults -> hs low for exactly 96 ce_pix cycles starting one pixel after hcnt=656; vs low for exactly 2 lines starting at vcnt=490; 640 de pixels per active line; 480 active lines.
REQ-041 ce_pix asserted every 3rd cycle -> all periods scale by 3; outputs stable on intervening cycles; frame_start width still 1 cycle.
REQ-042 Mode 1 -> pixel 0 is FFFFFF; pixel 80 is FFFF00; pixel 560 is 000000; r/g/b=0 at hcnt 640..799.
REQ-043 pattern_sel changed 0->2 at line 100 -> solid colour continues to end of frame; grid appears from the next frame_start.
REQ-044 reset_n pulsed low at hcnt=300, vcnt=200 -> all outputs are at their reset values asynchronously; counting restarts from 0,0 with frame_start on the first ce_pix edge.
REQ-045 HS_POL=1, H_ACTIVE=320, H_FP=H_SYNC=H_BP=8 -> hs high for hcnt 328..335; line period 344.

Source files
------------

// File: rtl/pgm_video_timing.sv
// Programmable raster timing generator with built-in test patterns.
// Counters advance on ce_pix; every other output is a registered view of the pre-edge position.
`timescale 1ns/1ps
module pgm_video_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = 12
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             ce_pix,
  input  logic [1:0]       pattern_sel,
  input  logic [23:0]      solid_rgb,
  input  logic [23:0]      rgb_in,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic             hblank,
  output logic             vblank,
  output logic [7:0]       r,
  output logic [7:0]       g,
  output logic [7:0]       b,
  output logic             frame_start,
  output logic             line_start
);

  localparam int HT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(HT - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(VT - 1);
  localparam logic [CNT_W-1:0] H_ACT_C   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] BAR_LAST  = CNT_W'(BAR_W - 1);

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_GRID  = 2'd2,
    MODE_PASS  = 2'd3
  } mode_t;

  logic [CNT_W-1:0] r_hcnt, r_vcnt;
  logic [CNT_W-1:0] r_bar_pos;
  logic [2:0]       r_bar_idx;
  mode_t            r_mode;
  logic             r_hs, r_vs, r_de, r_hblank, r_vblank;
  logic             r_frame_start, r_line_start;
  logic [23:0]      r_rgb;

  logic        w_h_last, w_v_last, w_line0, w_frame0;
  logic        w_hblank, w_vblank, w_de, w_hsync, w_vsync;
  mode_t       w_mode;
  logic [23:0] w_bar_rgb, w_rgb;

  assign w_h_last = (r_hcnt == H_LAST);
  assign w_v_last = (r_vcnt == V_LAST);
  assign w_line0  = (r_hcnt == '0);
  assign w_frame0 = w_line0 && (r_vcnt == '0);
  assign w_hblank = (r_hcnt >= H_ACT_C);
  assign w_vblank = (r_vcnt >= V_ACT_C);
  assign w_de     = ~w_hblank & ~w_vblank;
  assign w_hsync  = (r_hcnt >= HS_FIRST) && (r_hcnt <= HS_LAST);
  assign w_vsync  = (r_vcnt >= VS_FIRST) && (r_vcnt <= VS_LAST);

  // The first pixel of a frame already uses the newly selected mode.
  assign w_mode = w_frame0 ? mode_t'(pattern_sel) : r_mode;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (ce_pix) begin
      if (w_h_last) begin
        r_hcnt <= '0;
        r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
      end else begin
        r_hcnt <= r_hcnt + 1'b1;
      end
    end
  end

  // Bar index tracks the current hcnt; it saturates at bar 7 past the eighth bar.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_bar_pos <= '0;
      r_bar_idx <= '0;
    end else if (ce_pix) begin
      if (w_h_last) begin
        r_bar_pos <= '0;
        r_bar_idx <= '0;
      end else if (r_bar_pos == BAR_LAST) begin
        r_bar_pos <= '0;
        if (r_bar_idx != 3'd7) r_bar_idx <= r_bar_idx + 3'd1;
      end else begin
        r_bar_pos <= r_bar_pos + 1'b1;
      end
    end
  end

  assign w_bar_rgb = {{8{~r_bar_idx[1]}}, {8{~r_bar_idx[2]}}, {8{~r_bar_idx[0]}}};

  always_comb begin
    w_rgb = '0;
    if (w_de) begin
      case (w_mode)
        MODE_SOLID: w_rgb = solid_rgb;
        MODE_BARS:  w_rgb = w_bar_rgb;
        MODE_GRID:  w_rgb = ((r_hcnt[3:0] == 4'd0) || (r_vcnt[3:0] == 4'd0)) ? '1 : '0;
        MODE_PASS:  w_rgb = rgb_in;
        default:    w_rgb = '0;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_hs          <= ~HS_POL;
      r_vs          <= ~VS_POL;
      r_de          <= 1'b0;
      r_hblank      <= 1'b0;
      r_vblank      <= 1'b0;
      r_rgb         <= '0;
      r_mode        <= MODE_SOLID;
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
    end else begin
      r_line_start  <= ce_pix & w_line0;
      r_frame_start <= ce_pix & w_frame0;
      if (ce_pix) begin
        r_hs     <= w_hsync ? HS_POL : ~HS_POL;
        r_vs     <= w_vsync ? VS_POL : ~VS_POL;
        r_de     <= w_de;
        r_hblank <= w_hblank;
        r_vblank <= w_vblank;
        r_rgb    <= w_rgb;
        if (w_frame0) r_mode <= w_mode;
      end
    end
  end

  assign hcnt        = r_hcnt;
  assign vcnt        = r_vcnt;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign de          = r_de;
  assign hblank      = r_hblank;
  assign vblank      = r_vblank;
  assign r           = r_rgb[23:16];
  assign g           = r_rgb[15:8];
  assign b           = r_rgb[7:0];
  assign frame_start = r_frame_start;
  assign line_start  = r_line_start;

endmodule

// File: tb/tb_pgm_video_timing.sv
// Randomized bench for pgm_video_timing: a reduced raster checked every cycle against a
// position-from-edge-count model, plus a second instance for sync polarity and line period.
`timescale 1ns/1ps
module tb_pgm_video_timing;

  localparam int HA  = 64;
  localparam int HFP = 4;
  localparam int HSW = 8;
  localparam int HBP = 4;
  localparam int VA  = 20;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VBP = 3;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int FR  = HT * VT;

  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b1;
  logic        ce_pix = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [23:0] solid_rgb = '0;
  logic [23:0] rgb_in = '0;

  logic [11:0] hcnt, vcnt;
  logic        hs, vs, de, hblank, vblank, frame_start, line_start;
  logic [7:0]  r, g, b;

  logic [11:0] b_hcnt, b_vcnt;
  logic        b_hs, b_vs, b_de, b_hblank, b_vblank, b_frame_start, b_line_start;
  logic [7:0]  b_r, b_g, b_b;

  always #5 clk_sys = ~clk_sys;

  pgm_video_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(12)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(ce_pix), .pattern_sel(pattern_sel),
    .solid_rgb(solid_rgb), .rgb_in(rgb_in), .hcnt(hcnt), .vcnt(vcnt),
    .hs(hs), .vs(vs), .de(de), .hblank(hblank), .vblank(vblank),
    .r(r), .g(g), .b(b), .frame_start(frame_start), .line_start(line_start)
  );

  pgm_video_timing #(
    .H_ACTIVE(320), .H_FP(8), .H_SYNC(8), .H_BP(8),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .CNT_W(12)
  ) dut_b (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(1'b1), .pattern_sel(pattern_sel),
    .solid_rgb(solid_rgb), .rgb_in(rgb_in), .hcnt(b_hcnt), .vcnt(b_vcnt),
    .hs(b_hs), .vs(b_vs), .de(b_de), .hblank(b_hblank), .vblank(b_vblank),
    .r(b_r), .g(b_g), .b(b_b), .frame_start(b_frame_start), .line_start(b_line_start)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Model: n counts ce_pix edges since reset release; position is n mod HT / line mod VT.
  int          n;
  logic [1:0]  m_mode;
  logic        e_hs, e_vs, e_de, e_hb, e_vb, e_ls, e_fs;
  logic [23:0] e_rgb;

  function automatic logic [23:0] exp_pix(input logic [1:0] mode, input int h, input int v,
                                          input logic [23:0] sol, input logic [23:0] pin);
    int bar;
    if (h >= HA || v >= VA) return 24'h000000;
    case (mode)
      2'd0: return sol;
      2'd1: begin
        bar = h / (HA / 8);
        if (bar > 7) bar = 7;
        return BARS[bar];
      end
      2'd2: return ((h % 16 == 0) || (v % 16 == 0)) ? 24'hFFFFFF : 24'h000000;
      default: return pin;
    endcase
  endfunction

  task automatic model_reset();
    n = 0; m_mode = 2'd0;
    e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_hb = 1'b0; e_vb = 1'b0;
    e_ls = 1'b0; e_fs = 1'b0; e_rgb = '0;
  endtask

  task automatic compare_all();
    check("hcnt", 64'(hcnt), 64'(n % HT));
    check("vcnt", 64'(vcnt), 64'((n / HT) % VT));
    check("flags{hs,vs,de,hb,vb,ls,fs}",
          64'({hs, vs, de, hblank, vblank, line_start, frame_start}),
          64'({e_hs, e_vs, e_de, e_hb, e_vb, e_ls, e_fs}));
    check("rgb", 64'({r, g, b}), 64'(e_rgb));
  endtask

  task automatic step(input logic ce);
    logic [23:0] sol, pin;
    int h, v;
    ce_pix    = ce;
    solid_rgb = 24'($urandom);
    rgb_in    = 24'($urandom);
    sol = solid_rgb;
    pin = rgb_in;
    @(posedge clk_sys);
    #1;
    if (!reset_n) begin
      model_reset();
    end else if (ce) begin
      h = n % HT;
      v = (n / HT) % VT;
      if (h == 0 && v == 0) m_mode = pattern_sel;
      e_hb  = (h >= HA);
      e_vb  = (v >= VA);
      e_de  = !e_hb && !e_vb;
      e_hs  = (h >= HA + HFP && h < HA + HFP + HSW) ? 1'b0 : 1'b1;
      e_vs  = (v >= VA + VFP && v < VA + VFP + VSW) ? 1'b0 : 1'b1;
      e_ls  = (h == 0);
      e_fs  = (h == 0 && v == 0);
      e_rgb = exp_pix(m_mode, h, v, sol, pin);
      n++;
    end else begin
      e_ls = 1'b0;
      e_fs = 1'b0;
    end
    compare_all();
  endtask

  int de_cnt, fs_cnt, hs_low_cnt, first_fs, second_fs, first_ls, second_ls;
  int last_ls, rise_h, run_len;
  bit in_run, got_per, got_run;
  logic prev_hs;

  initial begin
    model_reset();
    #1 reset_n = 1'b0;
    #1 compare_all();
    step(1'b0);
    for (int i = 0; i < 4; i++) step(1'b1);
    reset_n = 1'b1;

    // Solid until line 10, then grid requested; grid must only appear from the next frame.
    pattern_sel = 2'd0;
    de_cnt = 0; fs_cnt = 0; hs_low_cnt = 0;
    for (int i = 0; i < 2 * FR; i++) begin
      if (i == 10 * HT) pattern_sel = 2'd2;
      step(1'b1);
      if (de) de_cnt++;
      if (frame_start) fs_cnt++;
      if (!hs) hs_low_cnt++;
    end
    check("de_pixels_2frames", 64'(de_cnt), 64'(2 * HA * VA));
    check("frame_starts_2frames", 64'(fs_cnt), 64'(2));
    check("hs_low_2frames", 64'(hs_low_cnt), 64'(2 * VT * HSW));

    for (int i = 0; i < 4 * FR; i++) begin
      if ($urandom_range(0, 199) == 0) pattern_sel = 2'($urandom);
      step(1'b1);
    end

    // ce_pix every third cycle in bar mode: periods scale by three.
    pattern_sel = 2'd1;
    first_fs = -1; second_fs = -1; first_ls = -1; second_ls = -1;
    for (int i = 0; i < 3 * FR + 3; i++) begin
      step((i % 3) == 0);
      if (frame_start) begin
        if (first_fs < 0) first_fs = i;
        else if (second_fs < 0) second_fs = i;
      end
      if (line_start) begin
        if (first_ls < 0) first_ls = i;
        else if (second_ls < 0) second_ls = i;
      end
    end
    check("frame_period_ce3", 64'(second_fs - first_fs), 64'(3 * FR));
    check("line_period_ce3", 64'(second_ls - first_ls), 64'(3 * HT));

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) pattern_sel = 2'($urandom);
      step(1'($urandom));
    end

    // Mid-frame asynchronous reset at line 10, pixel 30.
    for (int i = 0; i < 2 * FR; i++) begin
      if ((n % HT) == 30 && ((n / HT) % VT) == 10) break;
      step(1'b1);
    end
    check("reached_reset_point", 64'({hcnt, vcnt}), 64'({12'd30, 12'd10}));
    #2 reset_n = 1'b0;
    model_reset();
    #1 compare_all();
    for (int i = 0; i < 3; i++) step(1'b1);
    reset_n = 1'b1;
    pattern_sel = 2'd3;
    step(1'b1);
    check("frame_start_after_release", 64'({frame_start, line_start}), 64'(2'b11));
    for (int i = 0; i < 200; i++) step(1'b1);

    // Second instance: HS_POL=1, 320/8/8/8 raster.
    last_ls = -1; in_run = 0; got_per = 0; got_run = 0; run_len = 0; rise_h = 0;
    prev_hs = b_hs;
    for (int i = 0; i < 800; i++) begin
      step(1'b1);
      if (b_line_start) begin
        if (last_ls >= 0 && !got_per) begin
          check("b_line_period", 64'(i - last_ls), 64'(344));
          got_per = 1;
        end
        last_ls = i;
      end
      if (b_hs && !prev_hs) begin
        rise_h = int'(b_hcnt) - 1;
        run_len = 0;
        in_run = 1;
      end
      if (b_hs) run_len++;
      if (!b_hs && prev_hs && in_run && !got_run) begin
        check("b_hs_width", 64'(run_len), 64'(8));
        check("b_hs_first_hcnt", 64'(rise_h), 64'(328));
        got_run = 1;
      end
      prev_hs = b_hs;
    end
    check("b_period_seen", 64'(got_per), 64'(1));
    check("b_hs_run_seen", 64'(got_run), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
